// File: rtl/image_strip_assembler.sv
// Image strip assembler: receives HEIGHT-bit column strips one per handshake,
// writes them into an image buffer from column 0 upward, tracks the leftmost
// column that holds a 1, and offers the finished image downstream.
module image_strip_assembler #(
  parameter  int HEIGHT = 200,
  parameter  int LENGTH = 200,
  localparam int COL_W  = (LENGTH > 1) ? $clog2(LENGTH) : 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           clear,
  input  logic [HEIGHT-1:0]              strip_in,
  input  logic                           strip_valid,
  input  logic                           strip_last,
  output logic                           strip_ready,
  output logic [HEIGHT-1:0][LENGTH-1:0]  image_out,
  output logic                           image_valid,
  input  logic                           image_ready,
  output logic [COL_W-1:0]               leftmost_col,
  output logic                           leftmost_found,
  output logic [COL_W:0]                 col_count
);

  typedef enum logic {
    S_FILL = 1'b0,
    S_HOLD = 1'b1
  } state_e;

  localparam logic [COL_W:0] LAST_COL = (COL_W + 1)'(LENGTH - 1);

  state_e                          state_q, state_d;
  logic                            live_q, live_d;
  logic [HEIGHT-1:0][LENGTH-1:0]   image_q, image_d;
  logic [COL_W:0]                  col_count_q, col_count_d;
  logic [COL_W-1:0]                leftmost_col_q, leftmost_col_d;
  logic                            leftmost_found_q, leftmost_found_d;

  logic                            accept;
  logic [COL_W-1:0]                col_idx;

  // Handshake flags come straight from registers; live_q keeps ready low in reset.
  assign strip_ready    = (state_q == S_FILL) & live_q;
  assign image_valid    = (state_q == S_HOLD);
  assign accept         = strip_valid & strip_ready;
  assign col_idx        = col_count_q[COL_W-1:0];

  assign image_out      = image_q;
  assign col_count      = col_count_q;
  assign leftmost_col   = leftmost_col_q;
  assign leftmost_found = leftmost_found_q;

  // Next-state and datapath update: clear, then fill or hold behaviour.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
    state_d          = state_q;
    live_d           = 1'b1;
    image_d          = image_q;
    col_count_d      = col_count_q;
    leftmost_col_d   = leftmost_col_q;
    leftmost_found_d = leftmost_found_q;

    if (clear) begin
      state_d          = S_FILL;
      image_d          = '0;
      col_count_d      = '0;
      leftmost_col_d   = '0;
      leftmost_found_d = 1'b0;
    end else begin
      unique case (state_q)
        S_FILL: begin
          if (accept) begin
            for (int j = 0; j < HEIGHT; j++) begin
              image_d[j][col_idx] = strip_in[j];
            end
            col_count_d = col_count_q + 1'b1;
            if (!leftmost_found_q && (|strip_in)) begin
              leftmost_col_d   = col_idx;
              leftmost_found_d = 1'b1;
            end
            // Last column or early end-of-frame both finish the image.
            if ((col_count_q == LAST_COL) || strip_last) begin
              state_d = S_HOLD;
            end
          end
        end
        S_HOLD: begin
          // Buffer is zeroed on release so a short next frame leaves zeros behind.
          if (image_ready) begin
            state_d          = S_FILL;
            image_d          = '0;
            col_count_d      = '0;
            leftmost_col_d   = '0;
            leftmost_found_d = 1'b0;
          end
        end
        default: state_d = S_FILL;
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the image buffer is reset too, since it is a visible output that must read zero.
      state_q          <= S_FILL;
      live_q           <= 1'b0;
      image_q          <= '0;
      col_count_q      <= '0;
      leftmost_col_q   <= '0;
      leftmost_found_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so all flops update together from pre-edge values.
      state_q          <= state_d;
      live_q           <= live_d;
      image_q          <= image_d;
      col_count_q      <= col_count_d;
      leftmost_col_q   <= leftmost_col_d;
      leftmost_found_q <= leftmost_found_d;
    end
  end

endmodule

// File: tb/tb_image_strip_assembler.sv
// Directed bench for image_strip_assembler with a 4x4 image.
module tb_image_strip_assembler;

  localparam int HEIGHT = 4;
  localparam int LENGTH = 4;
  localparam int COL_W  = 2;

  logic                          clk;
  logic                          rst_n;
  logic                          clear;
  logic [HEIGHT-1:0]             strip_in;
  logic                          strip_valid;
  logic                          strip_last;
  logic                          strip_ready;
  logic [HEIGHT-1:0][LENGTH-1:0] image_out;
  logic                          image_valid;
  logic                          image_ready;
  logic [COL_W-1:0]              leftmost_col;
  logic                          leftmost_found;
  logic [COL_W:0]                col_count;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  logic [15:0] held_image;

  image_strip_assembler #(.HEIGHT(HEIGHT), .LENGTH(LENGTH)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .clear          (clear),
    .strip_in       (strip_in),
    .strip_valid    (strip_valid),
    .strip_last     (strip_last),
    .strip_ready    (strip_ready),
    .image_out      (image_out),
    .image_valid    (image_valid),
    .image_ready    (image_ready),
    .leftmost_col   (leftmost_col),
    .leftmost_found (leftmost_found),
    .col_count      (col_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Present one strip for exactly one clock edge; returns #1 after that edge.
  task automatic send_strip(input logic [HEIGHT-1:0] data, input logic last);
    strip_in    = data;
    strip_valid = 1'b1;
    strip_last  = last;
    @(posedge clk); #1;
    strip_valid = 1'b0;
    strip_last  = 1'b0;
    strip_in    = '0;
  endtask

  // Consume the held image and confirm the buffer comes back empty and ready.
  task automatic release_image(input string tag);
    image_ready = 1'b1;
    @(posedge clk); #1;
    image_ready = 1'b0;
    check({tag, "_rel_valid"}, 32'(image_valid), 32'd0);
    check({tag, "_rel_ready"}, 32'(strip_ready), 32'd1);
    check({tag, "_rel_image"}, 32'(image_out),   32'h0);
    check({tag, "_rel_count"}, 32'(col_count),   32'd0);
  endtask

  initial begin
    rst_n       = 1'b0;
    clear       = 1'b0;
    strip_in    = '0;
    strip_valid = 1'b0;
    strip_last  = 1'b0;
    image_ready = 1'b0;

    // Reset values
    #12;
    check("rst_ready", 32'(strip_ready),    32'd0);
    check("rst_valid", 32'(image_valid),    32'd0);
    check("rst_image", 32'(image_out),      32'h0);
    check("rst_count", 32'(col_count),      32'd0);
    check("rst_found", 32'(leftmost_found), 32'd0);
    #10 rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_ready", 32'(strip_ready), 32'd1);

    // Frame 1: 0,0,5,A back-to-back
    send_strip(4'h0, 1'b0);
    send_strip(4'h0, 1'b0);
    send_strip(4'h5, 1'b0);
    check("f1_valid_early", 32'(image_valid), 32'd0);
    check("f1_count3",      32'(col_count),   32'd3);
    send_strip(4'hA, 1'b0);
    check("f1_valid", 32'(image_valid),    32'd1);
    check("f1_ready", 32'(strip_ready),    32'd0);
    check("f1_image", 32'(image_out),      32'h8484);
    check("f1_left",  32'(leftmost_col),   32'd2);
    check("f1_found", 32'(leftmost_found), 32'd1);
    check("f1_count", 32'(col_count),      32'd4);
    release_image("f1");

    // Frame 2: early strip_last after two strips
    send_strip(4'h1, 1'b0);
    send_strip(4'hF, 1'b1);
    check("f2_valid", 32'(image_valid),    32'd1);
    check("f2_count", 32'(col_count),      32'd2);
    check("f2_image", 32'(image_out),      32'h2223);
    check("f2_left",  32'(leftmost_col),   32'd0);
    check("f2_found", 32'(leftmost_found), 32'd1);
    release_image("f2");

    // Frame 3: hold for 10 cycles with ignored strip pulses
    send_strip(4'h3, 1'b0);
    send_strip(4'hC, 1'b0);
    send_strip(4'h9, 1'b0);
    send_strip(4'h6, 1'b0);
    held_image = 16'h6A95;
    check("f3_image", 32'(image_out), 32'(held_image));
    for (int k = 0; k < 10; k++) begin
      strip_in    = 4'hF;
      strip_valid = k[0];
      strip_last  = k[0];
      @(posedge clk); #1;
      check("f3_hold_valid", 32'(image_valid), 32'd1);
      check("f3_hold_ready", 32'(strip_ready), 32'd0);
      check("f3_hold_image", 32'(image_out),   32'(held_image));
      check("f3_hold_count", 32'(col_count),   32'd4);
    end
    strip_valid = 1'b0;
    strip_last  = 1'b0;
    strip_in    = '0;
    release_image("f3");

    // Frame 4: all-zero strips
    for (int k = 0; k < 4; k++) send_strip(4'h0, 1'b0);
    check("f4_valid", 32'(image_valid),    32'd1);
    check("f4_found", 32'(leftmost_found), 32'd0);
    check("f4_left",  32'(leftmost_col),   32'd0);
    check("f4_image", 32'(image_out),      32'h0);
    release_image("f4");

    // Frame 5: clear mid-frame with a strip offered on the same cycle
    send_strip(4'h8, 1'b0);
    send_strip(4'h4, 1'b0);
    check("f5_count2", 32'(col_count), 32'd2);
    clear       = 1'b1;
    strip_in    = 4'hF;
    strip_valid = 1'b1;
    @(posedge clk); #1;
    clear       = 1'b0;
    strip_valid = 1'b0;
    strip_in    = '0;
    check("f5_clr_count", 32'(col_count),      32'd0);
    check("f5_clr_image", 32'(image_out),      32'h0);
    check("f5_clr_found", 32'(leftmost_found), 32'd0);
    check("f5_clr_ready", 32'(strip_ready),    32'd1);
    check("f5_clr_valid", 32'(image_valid),    32'd0);
    send_strip(4'h0, 1'b0);
    send_strip(4'h0, 1'b0);
    send_strip(4'h0, 1'b0);
    send_strip(4'h2, 1'b0);
    check("f5_image", 32'(image_out),    32'h0080);
    check("f5_left",  32'(leftmost_col), 32'd3);
    release_image("f5");

    // Frame 6: asynchronous reset mid-frame, then a fresh frame
    send_strip(4'hF, 1'b0);
    send_strip(4'hF, 1'b0);
    send_strip(4'hF, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("f6_arst_image", 32'(image_out),      32'h0);
    check("f6_arst_count", 32'(col_count),      32'd0);
    check("f6_arst_found", 32'(leftmost_found), 32'd0);
    check("f6_arst_ready", 32'(strip_ready),    32'd0);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    check("f6_ready", 32'(strip_ready), 32'd1);
    send_strip(4'h1, 1'b0);
    send_strip(4'h2, 1'b0);
    send_strip(4'h4, 1'b0);
    send_strip(4'h8, 1'b0);
    check("f6_valid", 32'(image_valid),    32'd1);
    check("f6_image", 32'(image_out),      32'h8421);
    check("f6_left",  32'(leftmost_col),   32'd0);
    check("f6_found", 32'(leftmost_found), 32'd1);
    check("f6_count", 32'(col_count),      32'd4);
    release_image("f6");

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
